// File: rtl/rvv_pkg.sv
// Shared RVV definitions: SEW encodings, sequencer state and per-SEW geometry helpers.
package rvv_pkg;

    typedef enum logic [1:0] {
        Sew8  = 2'd0,
        Sew16 = 2'd1,
        Sew32 = 2'd2,
        Sew64 = 2'd3
    } sew_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // log2 of elements per beat; saturates at 0 when the element is wider than the beat
    function automatic int unsigned lg_epb(input int unsigned lg_dw_b, input int unsigned sew);
        return (sew > lg_dw_b) ? 0 : lg_dw_b - sew;
    endfunction

    // Elements per beat (EPB = DW_B >> sew)
    function automatic int unsigned epb(input int unsigned dw_b, input int unsigned sew);
        return dw_b >> sew;
    endfunction

    // Bytes per element (W_B = 1 << sew)
    function automatic int unsigned w_b(input int unsigned sew);
        return 32'd1 << sew;
    endfunction

endpackage

// File: rtl/be_lane_gen.sv
// Byte-enable generator for one beat: byte b belongs to element beat*EPB + (b >> sew),
// and is enabled when that element lies in [vstart, avl).
module be_lane_gen
    import rvv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH  = 2,
    parameter int unsigned AVL_WIDTH  = 12
) (
    input  logic [SEW_WIDTH-1:0]    sew,
    input  logic [AVL_WIDTH-1:0]    vstart,
    input  logic [AVL_WIDTH-1:0]    avl,
    input  logic [AVL_WIDTH-1:0]    beat,
    output logic [DATA_WIDTH/8-1:0] be
);

    localparam int unsigned DwB   = DATA_WIDTH / 8;
    localparam int unsigned LgDwB = $clog2(DwB);

    logic [AVL_WIDTH-1:0] base;
    logic [AVL_WIDTH-1:0] elem [DwB];

    // Element index of every byte lane, then range test against [vstart, avl)
    always_comb begin
        base = beat << lg_epb(LgDwB, 32'(sew));
        be   = '0;
        for (int b = 0; b < DwB; b++) begin
            elem[b] = base + (AVL_WIDTH'(b) >> sew);
            be[b]   = (elem[b] >= vstart) && (elem[b] < avl);
        end
    end

endmodule

// File: rtl/generate_be_seq.sv
// Byte-enable sequencer: walks the beats covering elements [vstart, avl) for a given SEW and
// presents registered per-beat byte enables plus a mask-qualified copy.
module generate_be_seq
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN          = 16384,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned SEW_WIDTH     = 2,
    parameter bit          ENABLE_64_BIT = 1'b1,
    localparam int unsigned DW_B         = DATA_WIDTH / 8,
    localparam int unsigned AVL_WIDTH    = $clog2(VLEN / 8) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEW_WIDTH-1:0] req_sew,
    input  logic [AVL_WIDTH-1:0] req_avl,
    input  logic [AVL_WIDTH-1:0] req_vstart,
    input  logic                 req_mask_en,
    input  logic [DW_B-1:0]      mask_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AVL_WIDTH-1:0] out_beat,
    output logic [DW_B-1:0]      out_be,
    output logic [DW_B-1:0]      out_be_m,
    output logic                 out_last,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned LgDwB = $clog2(DW_B);
    localparam int unsigned SlotW = (LgDwB > 0) ? LgDwB : 1;

    state_e               state_q, state_d;
    logic [SEW_WIDTH-1:0] sew_q;
    logic [AVL_WIDTH-1:0] avl_q, vstart_q;
    logic                 mask_en_q;
    logic [AVL_WIDTH-1:0] beat_q, last_beat_q;
    logic [DW_B-1:0]      out_be_q;
    logic                 out_last_q;
    logic                 done_q, err_q;

    logic                 accept, start, handshake, final_hs;
    logic                 req_empty, req_illegal;
    int unsigned          req_sh;
    logic [AVL_WIDTH-1:0] req_first, req_last, next_beat;

    logic [SEW_WIDTH-1:0] gen_sew;
    logic [AVL_WIDTH-1:0] gen_vstart, gen_avl, gen_beat;
    logic [DW_B-1:0]      gen_be;

    // Request decode: beat range by shifting, empty/illegal classification
    always_comb begin
        accept      = req_valid && req_ready;
        req_sh      = lg_epb(LgDwB, 32'(req_sew));
        req_first   = req_vstart >> req_sh;
        req_last    = (req_avl - 1'b1) >> req_sh;
        req_empty   = (req_avl == '0) || (req_vstart >= req_avl);
        // Element wider than the beat is also rejected so EPB never reaches zero
        req_illegal = ((req_sew == SEW_WIDTH'(Sew64)) && !ENABLE_64_BIT) ||
                      (32'(req_sew) > LgDwB);
        start       = accept && !req_empty && !req_illegal;
        handshake   = out_valid && out_ready;
        final_hs    = handshake && out_last_q;
        next_beat   = beat_q + 1'b1;
    end

    // Enable generator sees the incoming request in IDLE and the following beat in RUN
    always_comb begin
        if (state_q == StIdle) begin
            gen_sew    = req_sew;
            gen_vstart = req_vstart;
            gen_avl    = req_avl;
            gen_beat   = req_first;
        end else begin
            gen_sew    = sew_q;
            gen_vstart = vstart_q;
            gen_avl    = avl_q;
            gen_beat   = next_beat;
        end
    end

    be_lane_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEW_WIDTH  (SEW_WIDTH),
        .AVL_WIDTH  (AVL_WIDTH)
    ) u_be_lane_gen (
        .sew    (gen_sew),
        .vstart (gen_vstart),
        .avl    (gen_avl),
        .beat   (gen_beat),
        .be     (gen_be)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start)    state_d = StRun;
            StRun:  if (final_hs) state_d = StIdle;
            default:              state_d = StIdle;
        endcase
    end

    // Request latch, beat sequencing and registered beat outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sew_q       <= '0;
            avl_q       <= '0;
            vstart_q    <= '0;
            mask_en_q   <= 1'b0;
            beat_q      <= '0;
            last_beat_q <= '0;
            out_be_q    <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= accept && (req_empty || req_illegal);
            err_q  <= accept && req_illegal;
            if (start) begin
                sew_q       <= req_sew;
                avl_q       <= req_avl;
                vstart_q    <= req_vstart;
                mask_en_q   <= req_mask_en;
                beat_q      <= req_first;
                last_beat_q <= req_last;
                out_be_q    <= gen_be;
                out_last_q  <= (req_first == req_last);
            end else if (handshake && !out_last_q) begin
                beat_q     <= next_beat;
                out_be_q   <= gen_be;
                out_last_q <= (next_beat == last_beat_q);
            end
        end
    end

    // Handshake and status outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !done_q;
        out_valid = (state_q == StRun);
        // Reset aborts a transfer silently, even on the last beat
        done      = done_q || (final_hs && !rst);
        err       = err_q;
    end

    // Beat outputs; mask qualification is combinational on the live mask_in
    always_comb begin
        out_beat = beat_q;
        out_be   = out_be_q;
        out_last = out_last_q;
        out_be_m = '0;
        for (int b = 0; b < DW_B; b++) begin
            out_be_m[b] = out_be_q[b] & (~mask_en_q | mask_in[SlotW'(b) >> sew_q]);
        end
    end

endmodule
